// File: rtl/input_debounce_2ch.sv
// Two-channel synchroniser and debouncer feeding the AND-gate stage.
// Each channel: 2-flop synchroniser, 4-state debounce FSM, registered level/edge outputs.

module input_debounce_2ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_raw,
  input  logic                b_raw,
  output logic                a,
  output logic                b,
  output logic                a_rise,
  output logic                a_fall,
  output logic                b_rise,
  output logic                b_fall,
  output logic [GLITCH_W-1:0] a_glitch_cnt,
  output logic [GLITCH_W-1:0] b_glitch_cnt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0]     CntOne    = CntW'(1);
  localparam logic [CntW-1:0]     CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GlitchOne = GLITCH_W'(1);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  logic [1:0]          raw;
  logic [1:0]          level;
  logic [1:0]          rise;
  logic [1:0]          fall;
  logic [GLITCH_W-1:0] glitch [2];

  assign raw = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic                s1_q, s_q;
    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                abort;

    // State register; reset wins over everything, so a WAIT cut short by reset is not a glitch.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q     <= 1'b0;
        s_q      <= 1'b0;
        state_q  <= StStableLo;
        cnt_q    <= '0;
        glitch_q <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        s1_q     <= raw[ch];
        s_q      <= s1_q;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        glitch_q <= glitch_d;
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort   = 1'b0;
      unique case (state_q)
        StStableLo: begin
          if (s_q) begin
            state_d = StWaitHi;
            cnt_d   = CntOne;
          end
        end
        StWaitHi: begin
          if (!s_q) begin
            state_d = StStableLo;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d = StStableHi;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStableHi: begin
          if (!s_q) begin
            state_d = StWaitLo;
            cnt_d   = CntOne;
          end
        end
        StWaitLo: begin
          if (s_q) begin
            state_d = StStableHi;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d = StStableLo;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StStableLo;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are computed from the next state so they register on the accepting edge.
    always_comb begin
      level_d  = (state_d == StStableHi) || (state_d == StWaitLo);
      rise_d   = (state_q == StWaitHi) && (state_d == StStableHi);
      fall_d   = (state_q == StWaitLo) && (state_d == StStableLo);
      glitch_d = glitch_q;
      if (abort && (glitch_q != '1)) begin
        glitch_d = glitch_q + GlitchOne;
      end
    end

    assign level[ch]  = level_q;
    assign rise[ch]   = rise_q;
    assign fall[ch]   = fall_q;
    assign glitch[ch] = glitch_q;
  end

  assign a            = level[0];
  assign b            = level[1];
  assign a_rise       = rise[0];
  assign a_fall       = fall[0];
  assign b_rise       = rise[1];
  assign b_fall       = fall[1];
  assign a_glitch_cnt = glitch[0];
  assign b_glitch_cnt = glitch[1];

endmodule

// File: tb/tb_input_debounce_2ch.sv
// Directed bench for input_debounce_2ch with DEBOUNCE_CYCLES=4, GLITCH_W=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.

module tb_input_debounce_2ch;

  logic       clk;
  logic       rst_n;
  logic       a_raw;
  logic       b_raw;
  logic       a;
  logic       b;
  logic       a_rise;
  logic       a_fall;
  logic       b_rise;
  logic       b_fall;
  logic [7:0] a_glitch_cnt;
  logic [7:0] b_glitch_cnt;

  int checks = 0;
  int errors = 0;

  input_debounce_2ch #(
    .DEBOUNCE_CYCLES(4),
    .GLITCH_W       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .a           (a),
    .b           (b),
    .a_rise      (a_rise),
    .a_fall      (a_fall),
    .b_rise      (b_rise),
    .b_fall      (b_fall),
    .a_glitch_cnt(a_glitch_cnt),
    .b_glitch_cnt(b_glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_glitch;

  initial begin
    rst_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step();
    step();
    check("reset_a", {31'd0, a}, 32'd0);
    check("reset_b", {31'd0, b}, 32'd0);
    check("reset_pulses", {28'd0, a_rise, a_fall, b_rise, b_fall}, 32'd0);
    check("reset_a_glitch", {24'd0, a_glitch_cnt}, 32'd0);
    check("reset_b_glitch", {24'd0, b_glitch_cnt}, 32'd0);

    // Idle low for 20 cycles after release.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_levels", {30'd0, a, b}, 32'd0);
      check("idle_pulses", {28'd0, a_rise, a_fall, b_rise, b_fall}, 32'd0);
    end
    check("idle_a_glitch", {24'd0, a_glitch_cnt}, 32'd0);
    check("idle_b_glitch", {24'd0, b_glitch_cnt}, 32'd0);

    // Clean rise on A: a and a_rise change after edge 5.
    a_raw = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      check("rise_a", {31'd0, a}, (e >= 5) ? 32'd1 : 32'd0);
      check("rise_a_pulse", {31'd0, a_rise}, (e == 5) ? 32'd1 : 32'd0);
      check("rise_a_nofall", {31'd0, a_fall}, 32'd0);
      check("rise_b_quiet", {31'd0, b}, 32'd0);
    end
    check("rise_a_glitch", {24'd0, a_glitch_cnt}, 32'd0);

    // Clean fall on A back to idle.
    a_raw = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      step();
      check("fall_a", {31'd0, a}, (e >= 5) ? 32'd0 : 32'd1);
      check("fall_a_pulse", {31'd0, a_fall}, (e == 5) ? 32'd1 : 32'd0);
      check("fall_a_norise", {31'd0, a_rise}, 32'd0);
    end

    // Three 3-cycle bursts: one sample short of acceptance, each rejected.
    for (int k = 0; k < 3; k++) begin
      a_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("burst_a_hi", {31'd0, a}, 32'd0);
        check("burst_a_nopulse", {30'd0, a_rise, a_fall}, 32'd0);
      end
      a_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        check("burst_a_lo", {31'd0, a}, 32'd0);
        check("burst_a_nopulse", {30'd0, a_rise, a_fall}, 32'd0);
      end
      check("burst_a_glitch", {24'd0, a_glitch_cnt}, k + 1);
    end
    check("burst_b_glitch", {24'd0, b_glitch_cnt}, 32'd0);

    // Simultaneous rise on both channels; y must go high once.
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      check("both_a", {31'd0, a}, (e >= 5) ? 32'd1 : 32'd0);
      check("both_b", {31'd0, b}, (e >= 5) ? 32'd1 : 32'd0);
      check("both_y", {31'd0, a & b}, (e >= 5) ? 32'd1 : 32'd0);
      check("both_a_rise", {31'd0, a_rise}, (e == 5) ? 32'd1 : 32'd0);
      check("both_b_rise", {31'd0, b_rise}, (e == 5) ? 32'd1 : 32'd0);
    end

    // 301 two-cycle low pulses with a high: each rejected, counter saturates at 255.
    exp_glitch = 3;
    for (int k = 0; k < 301; k++) begin
      a_raw = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (i == 2) a_raw = 1'b1;
        step();
        check("sat_a_held", {31'd0, a}, 32'd1);
        check("sat_a_nopulse", {30'd0, a_rise, a_fall}, 32'd0);
      end
      exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
      check("sat_a_glitch", {24'd0, a_glitch_cnt}, exp_glitch);
    end
    check("sat_a_final", {24'd0, a_glitch_cnt}, 32'd255);
    check("sat_b_glitch", {24'd0, b_glitch_cnt}, 32'd0);
    check("sat_b_held", {31'd0, b}, 32'd1);

    // Let A fall, then reset in the middle of the next rise's WAIT.
    a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("pre_rst_a", {31'd0, a}, 32'd0);
    a_raw = 1'b1;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midwait_rst_a", {31'd0, a}, 32'd0);
    check("midwait_rst_b", {31'd0, b}, 32'd0);
    check("midwait_rst_a_glitch", {24'd0, a_glitch_cnt}, 32'd0);
    check("midwait_rst_b_glitch", {24'd0, b_glitch_cnt}, 32'd0);
    check("midwait_rst_pulses", {28'd0, a_rise, a_fall, b_rise, b_fall}, 32'd0);
    rst_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      check("post_rst_a", {31'd0, a}, (e >= 5) ? 32'd1 : 32'd0);
      check("post_rst_a_rise", {31'd0, a_rise}, (e == 5) ? 32'd1 : 32'd0);
      check("post_rst_b", {31'd0, b}, (e >= 5) ? 32'd1 : 32'd0);
      check("post_rst_b_rise", {31'd0, b_rise}, (e == 5) ? 32'd1 : 32'd0);
      check("post_rst_a_glitch", {24'd0, a_glitch_cnt}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce_2ch.md
Name: input_debounce_2ch

Overview:
- Two-channel synchroniser and debouncer that sits directly upstream of the 2-input AND gate stage.
- Takes raw, asynchronous, bouncy switch/pin levels and drives clean, glitch-free levels `a` and `b` into the gate's `a`/`b` inputs.
- Also emits single-cycle edge pulses and per-channel glitch counts for bench and debug visibility.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive synchronised samples at the new level needed to accept a transition. Legal range 2..255.
- GLITCH_W, 8: width of each saturating glitch counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a_raw  input  1  raw asynchronous level, channel A.
- b_raw  input  1  raw asynchronous level, channel B.
- a  output  1  debounced level, channel A; feeds AND-gate input a.
- b  output  1  debounced level, channel B; feeds AND-gate input b.
- a_rise  output  1  one-cycle pulse when `a` goes 0->1.
- a_fall  output  1  one-cycle pulse when `a` goes 1->0.
- b_rise  output  1  one-cycle pulse when `b` goes 0->1.
- b_fall  output  1  one-cycle pulse when `b` goes 1->0.
- a_glitch_cnt  output  GLITCH_W  count of rejected transitions, channel A.
- b_glitch_cnt  output  GLITCH_W  count of rejected transitions, channel B.

Behaviour:
- Channels A and B are identical and fully independent; only channel A is described.
- Synchroniser:
  - Two flops, a_raw -> s1 -> s.
  - Only s is used downstream; a_raw is never used directly.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- Counter: cnt, width clog2(DEBOUNCE_CYCLES+1).
- STABLE_LO:
  - s=1 -> WAIT_HI, cnt=1.
  - Otherwise stay.
- WAIT_HI:
  - s=0 -> STABLE_LO, cnt=0, glitch_cnt+1.
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0.
  - Otherwise cnt+1.
- STABLE_HI and WAIT_LO are the mirror of the above with levels swapped.
- Output `a`: registered; it is 1 exactly in states STABLE_HI and WAIT_LO.
  - It never changes while in a WAIT state.
- Edge pulses:
  - a_rise is high for the single cycle after the WAIT_HI->STABLE_HI edge.
  - a_fall is high for the single cycle after the WAIT_LO->STABLE_LO edge.
  - Pulses are registered, never combinational, and never coincide on the same channel.
- Latency:
  - Let edge 0 be the first clk edge at which a_raw is sampled at its new level, with the level held thereafter.
  - `a` and the matching pulse change after edge DEBOUNCE_CYCLES+1 (default: edge 5).
- Rejection:
  - Any return of s to the old level during WAIT aborts the transition.
  - `a` is unchanged and no pulse is emitted.
- Glitch counter:
  - Increments by 1 per aborted WAIT.
  - Saturates at all-ones and does not wrap.
- Reset (rst_n=0 at a rising edge):
  - s1, s, cnt, a, all pulses and glitch_cnt clear to 0; state goes to STABLE_LO.
  - Takes priority over all other events, including reset asserted mid-WAIT. The aborted WAIT is not counted as a glitch.
- After reset release with a_raw held 1:
  - A normal rise is accepted after DEBOUNCE_CYCLES+2 edges, counting edge 0 as the first edge with rst_n=1.
  - a_rise pulses once.
- Channels A and B may transition on the same cycle; each behaves independently.
- Downstream timing:
  - The AND-gate input sees `a`/`b` change only on clk edges.
  - Combined output y=a&b therefore switches at most once per clock.

Test Plan (DEBOUNCE_CYCLES=4, GLITCH_W=8):
- Reset release with a_raw=b_raw=0, held 20 cycles -> a=b=0, no pulses, both glitch_cnt=0.
- a_raw 0->1 held -> a rises after edge 5; a_rise high for exactly 1 cycle; a_glitch_cnt=0.
- a_raw high for 3 cycles then low, repeated 3 times with ≥6 cycles low between bursts -> a stays 0; a_glitch_cnt=3.
- a_raw and b_raw both 0->1 on the same cycle -> a, b, a_rise, b_rise all assert on the same cycle; y=a&b goes 1 once with no intermediate toggling.
- With a=1, set a_raw low for 2 cycles, then apply 300 such 2-cycle low pulses -> a stays 1 throughout; a_glitch_cnt saturates at 255.
- a_raw rises; rst_n driven 0 at edge 3 (mid-WAIT) for 1 cycle, then released with a_raw still 1 -> a=0 and glitch_cnt=0 after reset; a rises 6 edges after release; exactly one a_rise pulse.
